// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default widths and opcode encodings.
// Used by alu_unit and alu_shifter (optional feature macro: ALU_OVERFLOW_EN).
package alu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int OPRN_WIDTH = 6;

   localparam logic [OPRN_WIDTH-1:0] OPRN_ADD = 6'h01;
   localparam logic [OPRN_WIDTH-1:0] OPRN_SUB = 6'h02;
   localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = 6'h03;
   localparam logic [OPRN_WIDTH-1:0] OPRN_SRL = 6'h04;
   localparam logic [OPRN_WIDTH-1:0] OPRN_SLL = 6'h05;
   localparam logic [OPRN_WIDTH-1:0] OPRN_AND = 6'h06;
   localparam logic [OPRN_WIDTH-1:0] OPRN_OR  = 6'h07;
   localparam logic [OPRN_WIDTH-1:0] OPRN_NOR = 6'h08;
   localparam logic [OPRN_WIDTH-1:0] OPRN_SLT = 6'h09;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter (left or right, zero fill).
// The whole shift amount is honoured: any amount of DATA_WIDTH or more yields 0,
// rather than wrapping on the low bits of the amount.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = alu_pkg::DATA_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] amount,
   input  logic             left,
   output logic [WIDTH-1:0] result
);

   localparam int SHW = $clog2(WIDTH);

   logic too_far;

   // Any set bit above the in-range shift field means the shift clears everything.
   assign too_far = |amount[WIDTH-1:SHW];

   // Select direction and apply saturation.
   always_comb begin
      result = '0;
      if (!too_far) begin
         if (left) result = data << amount[SHW-1:0];
         else      result = data >> amount[SHW-1:0];
      end
   end

endmodule

// File: rtl/alu_unit.sv
// 32-bit integer ALU with a single registered output stage (1-cycle latency).
// ZERO is decoded combinationally from the registered result.
// Optional feature macro: ALU_OVERFLOW_EN adds a registered signed-overflow flag OVFL
// for ADD/SUB.
module alu_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
   parameter int OPRN_WIDTH = alu_pkg::OPRN_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] OP1,
   input  logic [DATA_WIDTH-1:0] OP2,
   input  logic [OPRN_WIDTH-1:0] OPRN,
`ifdef ALU_OVERFLOW_EN
   output logic                  OVFL,
`endif
   output logic [DATA_WIDTH-1:0] OUT,
   output logic                  ZERO
);

   logic [DATA_WIDTH-1:0] out_reg;
   logic [DATA_WIDTH-1:0] out_next;
   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] shift_res;
   logic                  shift_left;
   logic                  ovfl_next;

   assign sum        = OP1 + OP2;
   assign diff       = OP1 - OP2;
   assign shift_left = (OPRN == OPRN_SLL);

   alu_shifter #(
      .WIDTH (DATA_WIDTH)
   ) u_shifter (
      .data   (OP1),
      .amount (OP2),
      .left   (shift_left),
      .result (shift_res)
   );

   // Operation select; unknown opcodes fall through to zero.
   always_comb begin
      out_next  = '0;
      ovfl_next = 1'b0;
      case (OPRN)
         OPRN_ADD: begin
            out_next  = sum;
            ovfl_next = (OP1[DATA_WIDTH-1] == OP2[DATA_WIDTH-1]) &&
                        (sum[DATA_WIDTH-1] != OP1[DATA_WIDTH-1]);
         end
         OPRN_SUB: begin
            out_next  = diff;
            ovfl_next = (OP1[DATA_WIDTH-1] != OP2[DATA_WIDTH-1]) &&
                        (diff[DATA_WIDTH-1] != OP1[DATA_WIDTH-1]);
         end
         OPRN_MUL: out_next = OP1 * OP2;
         OPRN_SRL: out_next = shift_res;
         OPRN_SLL: out_next = shift_res;
         OPRN_AND: out_next = OP1 & OP2;
         OPRN_OR:  out_next = OP1 | OP2;
         OPRN_NOR: out_next = ~(OP1 | OP2);
         OPRN_SLT: out_next = {{(DATA_WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
         default:  out_next = '0;
      endcase
   end

   // Result register; reset clears it without waiting for a clock.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) out_reg <= '0;
      else      out_reg <= out_next;
   end

`ifdef ALU_OVERFLOW_EN
   logic ovfl_reg;

   // Overflow flag register, aligned with the result register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) ovfl_reg <= 1'b0;
      else      ovfl_reg <= ovfl_next;
   end

   assign OVFL = ovfl_reg;
`else
   logic unused_ovfl;
   assign unused_ovfl = ovfl_next;
`endif

   assign OUT  = out_reg;
   assign ZERO = (out_reg == '0);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed steps plus a few random vectors,
// expectations queued on drive and compared after the following clock edge.
// Build with ALU_OVERFLOW_EN defined to also check the OVFL port.
module tb_alu_unit;

   logic        CLK;
   logic        RST;
   logic [31:0] OP1;
   logic [31:0] OP2;
   logic [5:0]  OPRN;
   logic [31:0] OUT;
   logic        ZERO;
`ifdef ALU_OVERFLOW_EN
   logic        OVFL;
`endif

   int n_assert;
   int n_fail;

   typedef struct {
      logic [31:0] out;
      logic        ovfl;
      string       tag;
   } exp_t;

   exp_t sb[$];

   alu_unit dut (
      .CLK  (CLK),
      .RST  (RST),
      .OP1  (OP1),
      .OP2  (OP2),
      .OPRN (OPRN),
`ifdef ALU_OVERFLOW_EN
      .OVFL (OVFL),
`endif
      .OUT  (OUT),
      .ZERO (ZERO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Independent reference for the random vectors.
   function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
      logic [63:0] p;
      case (op)
         6'h01: return a + b;
         6'h02: return a - b;
         6'h03: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         6'h04: return (b > 32'd31) ? 32'd0 : (a >> b);
         6'h05: return (b > 32'd31) ? 32'd0 : (a << b);
         6'h06: return a & b;
         6'h07: return a | b;
         6'h08: return ~(a | b);
         6'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic push_exp(input logic [31:0] e_out, input logic e_ovfl, input string tag);
      exp_t e;
      e.out  = e_out;
      e.ovfl = e_ovfl;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the current outputs.
   task automatic check_front();
      exp_t e;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_assert++;
         assert (OUT === e.out) else begin
            n_fail++;
            $error("FAIL %s OUT observed=%h expected=%h", e.tag, OUT, e.out);
         end
         n_assert++;
         assert (ZERO === (e.out == 32'd0)) else begin
            n_fail++;
            $error("FAIL %s ZERO observed=%b expected=%b", e.tag, ZERO, (e.out == 32'd0));
         end
`ifdef ALU_OVERFLOW_EN
         n_assert++;
         assert (OVFL === e.ovfl) else begin
            n_fail++;
            $error("FAIL %s OVFL observed=%b expected=%b", e.tag, OVFL, e.ovfl);
         end
`endif
         $display("check %-10s OP=%h A=%h B=%h OUT=%h ZERO=%b", e.tag, OPRN, OP1, OP2, OUT, ZERO);
      end
   endtask

   // Drive one operation, then check it one edge later.
   task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_out, input logic e_ovfl, input string tag);
      @(negedge CLK);
      OPRN = op;
      OP1  = a;
      OP2  = b;
      push_exp(e_out, e_ovfl, tag);
      @(posedge CLK);
      #1;
      check_front();
   endtask

   initial begin
      logic [5:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      n_assert = 0;
      n_fail   = 0;

      // Reset with no clock edge: drive junk, then drop RST.
      RST  = 1'b1;
      OPRN = 6'h01;
      OP1  = 32'hdeadbeef;
      OP2  = 32'h12345678;
      #1 RST = 1'b0;
      #1;
      push_exp(32'd0, 1'b0, "reset");
      check_front();
      @(negedge CLK);
      RST = 1'b1;

      step(6'h01, 32'h001fb700, 32'h00000321, 32'h001fba21, 1'b0, "add");
      step(6'h02, 32'h000000ff, 32'h00000100, 32'hffffffff, 1'b0, "sub");
      step(6'h03, 32'h00008bf7, 32'h000000ab, 32'h005d7dfd, 1'b0, "mul");
      step(6'h04, 32'hffffffff, 32'h000000ff, 32'h00000000, 1'b0, "srl_big");
      step(6'h04, 32'hf0000000, 32'h00000004, 32'h0f000000, 1'b0, "srl");
      step(6'h05, 32'h00000001, 32'h00000002, 32'h00000004, 1'b0, "sll");
      step(6'h05, 32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, "sll_31");
      step(6'h05, 32'h00000001, 32'h00000020, 32'h00000000, 1'b0, "sll_32");
      step(6'h06, 32'h01a44bd0, 32'he78fa105, 32'h01840100, 1'b0, "and");
      step(6'h07, 32'h10101000, 32'h09780afd, 32'h19781afd, 1'b0, "or");
      step(6'h08, 32'h0fabd140, 32'h326f9ed1, 32'hc010202e, 1'b0, "nor");

      // Mid-stream reset clears OUT at once and holds across an edge.
      #2 RST = 1'b0;
      #1;
      push_exp(32'd0, 1'b0, "rst_mid");
      check_front();
      step(6'h01, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, "rst_hold");
      @(negedge CLK);
      RST = 1'b1;

      step(6'h09, 32'h0fffffff, 32'h10000000, 32'h00000001, 1'b0, "slt");
      step(6'h09, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, "slt_neg");
      step(6'h09, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, "slt_false");
      step(6'h3f, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, "undef_3f");
      step(6'h00, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, "op_00");
      step(6'h01, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1, "add_ovfl");
      step(6'h02, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, "sub_5_3");
      step(6'h02, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, "sub_ovfl");
      step(6'h03, 32'h7fffffff, 32'h7fffffff, 32'h00000001, 1'b0, "mul_ovfl0");

      // Random vectors against the reference model (overflow not modelled here,
      // so only opcodes without an overflow output are used).
      for (int i = 0; i < 12; i++) begin
         rop = 6'($urandom_range(3, 12));
         ra  = $urandom;
         rb  = (rop == 6'h04 || rop == 6'h05) ? 32'($urandom_range(0, 40)) : $urandom;
         step(rop, ra, rb, model(rop, ra, rb), 1'b0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
